// File: rtl/gf_seq_adder.sv
// Digit-serial integer / carry-less GF(2^m) adder; DIGIT_WIDTH bits per cycle, carry chained through a register.
// Latency: out_valid rises NUM_DIGITS cycles after the accept edge; one op per NUM_DIGITS+2 cycles minimum.
// Backpressure: in_ready only in IDLE; result and carry held stable in DONE until out_ready.
// Optional macro GF_SEQ_ADDER_SUB_EN: mode 2'b10 computes A-B as A + ~B + 1 (out_carry=1 means no borrow).
module gf_seq_adder #(
   parameter int DATA_WIDTH  = 32,
   parameter int DIGIT_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1:0]            in_mode,
   input  logic [DATA_WIDTH-1:0] in_sum_a,
   input  logic [DATA_WIDTH-1:0] in_sum_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_sum_result,
   output logic                  out_carry
);

   localparam int NUM_DIGITS = DATA_WIDTH / DIGIT_WIDTH;
   localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

   // A width that does not split into whole digits cannot be processed serially.
   generate
      if (DATA_WIDTH % DIGIT_WIDTH != 0) begin : g_bad_width
         $error("gf_seq_adder: DATA_WIDTH (%0d) must be a multiple of DIGIT_WIDTH (%0d)",
                DATA_WIDTH, DIGIT_WIDTH);
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                  state;
   logic [DATA_WIDTH-1:0]   a_q;
   logic [DATA_WIDTH-1:0]   b_q;
   logic [DATA_WIDTH-1:0]   acc_q;
   logic                    gf_q;
   logic                    carry_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [DATA_WIDTH-1:0]   out_sum_q;
   logic                    out_carry_q;
   logic                    out_valid_q;

   logic [DIGIT_WIDTH-1:0]  a_digit;
   logic [DIGIT_WIDTH-1:0]  b_digit;
   logic [DIGIT_WIDTH-1:0]  b_eff;
   logic [DIGIT_WIDTH:0]    digit_sum;
   logic [DIGIT_WIDTH-1:0]  digit;
   logic                    carry_next;
   logic [DATA_WIDTH-1:0]   acc_next;
   logic [DATA_WIDTH-1:0]   a_next;
   logic [DATA_WIDTH-1:0]   b_next;
   logic                    gf_sel;
   logic                    sub_sel;

`ifdef GF_SEQ_ADDER_SUB_EN
   logic                    sub_q;

   // Mode decode at accept: 01 is GF, 10 is subtract, 00/11 are integer add.
   always_comb begin
      gf_sel  = (in_mode == 2'b01);
      sub_sel = (in_mode == 2'b10);
   end

   // Subtraction feeds the inverted B digit; the +1 comes from the preset carry.
   always_comb begin
      b_eff = sub_q ? ~b_digit : b_digit;
   end
`else
   logic                    mode_hi_unused;

   assign mode_hi_unused = in_mode[1];

   // Without subtract support only the low mode bit matters: 10 acts as 00, 11 as 01.
   always_comb begin
      gf_sel  = in_mode[0];
      sub_sel = 1'b0;
   end

   // B digit passes straight through; no inversion path exists in this build.
   always_comb begin
      b_eff = b_digit;
   end
`endif

   // One digit of add (carry-chained) or carry-less XOR per RUN cycle.
   always_comb begin
      a_digit    = a_q[DIGIT_WIDTH-1:0];
      b_digit    = b_q[DIGIT_WIDTH-1:0];
      digit_sum  = (DIGIT_WIDTH+1)'(a_digit) + (DIGIT_WIDTH+1)'(b_eff) + (DIGIT_WIDTH+1)'(carry_q);
      digit      = gf_q ? (a_digit ^ b_digit) : digit_sum[DIGIT_WIDTH-1:0];
      carry_next = gf_q ? 1'b0 : digit_sum[DIGIT_WIDTH];
   end

   // Result digits enter at the MSB end; operands drain from the LSB end.
   generate
      if (NUM_DIGITS == 1) begin : g_single
         assign acc_next = digit;
         assign a_next   = '0;
         assign b_next   = '0;
      end else begin : g_multi
         assign acc_next = {digit, acc_q[DATA_WIDTH-1:DIGIT_WIDTH]};
         assign a_next   = {{DIGIT_WIDTH{1'b0}}, a_q[DATA_WIDTH-1:DIGIT_WIDTH]};
         assign b_next   = {{DIGIT_WIDTH{1'b0}}, b_q[DATA_WIDTH-1:DIGIT_WIDTH]};
      end
   endgenerate

   // Control FSM plus datapath registers; outputs load only on the final digit.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         gf_q        <= 1'b0;
         carry_q     <= 1'b0;
         cnt_q       <= '0;
         out_sum_q   <= '0;
         out_carry_q <= 1'b0;
         out_valid_q <= 1'b0;
`ifdef GF_SEQ_ADDER_SUB_EN
         sub_q       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= in_sum_a;
                  b_q     <= in_sum_b;
                  gf_q    <= gf_sel;
                  carry_q <= sub_sel;
                  cnt_q   <= '0;
`ifdef GF_SEQ_ADDER_SUB_EN
                  sub_q   <= sub_sel;
`endif
                  state   <= RUN;
               end
            end
            RUN: begin
               a_q     <= a_next;
               b_q     <= b_next;
               acc_q   <= acc_next;
               carry_q <= carry_next;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (cnt_q == LAST_DIGIT) begin
                  out_sum_q   <= acc_next;
                  out_carry_q <= carry_next;
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign in_ready       = (state == IDLE);
   assign out_valid      = out_valid_q;
   assign out_sum_result = out_sum_q;
   assign out_carry      = out_carry_q;

endmodule

// File: tb/tb_gf_seq_adder.sv
// Self-checking bench for gf_seq_adder: directed cases plus random ops against a plain-arithmetic model.
// Covers reset, int/GF add, backpressure, mode-10 handling, mid-op reset and a full-width-digit instance.
module tb_gf_seq_adder;

   logic        clk = 1'b0;
   logic        resetn;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_mode;
   logic [31:0] in_sum_a;
   logic [31:0] in_sum_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_sum_result;
   logic        out_carry;

   logic        v32_in_valid;
   logic        v32_in_ready;
   logic [1:0]  v32_in_mode;
   logic [31:0] v32_in_sum_a;
   logic [31:0] v32_in_sum_b;
   logic        v32_out_valid;
   logic        v32_out_ready;
   logic [31:0] v32_out_sum_result;
   logic        v32_out_carry;

   int pass_cnt  = 0;
   int fail_cnt  = 0;
   int total_cnt = 0;

`ifdef GF_SEQ_ADDER_SUB_EN
   localparam bit SUB_EN = 1'b1;
`else
   localparam bit SUB_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   gf_seq_adder dut (
      .clk(clk), .resetn(resetn),
      .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
      .in_sum_a(in_sum_a), .in_sum_b(in_sum_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum_result(out_sum_result), .out_carry(out_carry)
   );

   gf_seq_adder #(.DATA_WIDTH(32), .DIGIT_WIDTH(32)) dut32 (
      .clk(clk), .resetn(resetn),
      .in_valid(v32_in_valid), .in_ready(v32_in_ready), .in_mode(v32_in_mode),
      .in_sum_a(v32_in_sum_a), .in_sum_b(v32_in_sum_b),
      .out_valid(v32_out_valid), .out_ready(v32_out_ready),
      .out_sum_result(v32_out_sum_result), .out_carry(v32_out_carry)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: whole-word arithmetic, {carry, result}.
   function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
      bit gf;
      bit sub;
      gf  = SUB_EN ? (m == 2'b01) : m[0];
      sub = SUB_EN && (m == 2'b10);
      if (gf) return {1'b0, a ^ b};
      return {1'b0, a} + {1'b0, (sub ? ~b : b)} + 33'(sub);
   endfunction

   task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
      int w = 0;
      while (!in_ready && w < 100) begin
         @(posedge clk); #1;
         w++;
      end
      if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_sum_a = a;
      in_sum_b = b;
      in_mode  = m;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_sum_a = $urandom;
      in_sum_b = $urandom;
      in_mode  = 2'($urandom_range(0, 3));
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) check("out_valid_timeout", 64'(out_valid), 64'd1);
   endtask

   // Full op with optional stall in DONE; checks sum, carry, latency and the release handshake.
   task automatic run_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] m, input logic [31:0] exp_sum,
                            input logic exp_carry, input int stall);
      int lat;
      out_ready = (stall == 0);
      start_op(a, b, m);
      wait_done(lat);
      check({tag, "_lat"}, 64'(lat), 64'd4);
      check({tag, "_sum"}, 64'(out_sum_result), 64'(exp_sum));
      check({tag, "_carry"}, 64'(out_carry), 64'(exp_carry));
      if (stall > 0) begin
         repeat (stall) begin
            @(posedge clk); #1;
         end
         check({tag, "_hold_sum"}, 64'(out_sum_result), 64'(exp_sum));
         check({tag, "_hold_vld"}, 64'(out_valid), 64'd1);
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
      check({tag, "_released"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [1:0]  rm;
      logic [32:0] exp;
      logic [31:0] held_sum;
      int          lat;
      bit          bad;

      resetn        = 1'b0;
      in_valid      = 1'b0;
      in_mode       = 2'b00;
      in_sum_a      = '0;
      in_sum_b      = '0;
      out_ready     = 1'b1;
      v32_in_valid  = 1'b0;
      v32_in_mode   = 2'b00;
      v32_in_sum_a  = '0;
      v32_in_sum_b  = '0;
      v32_out_ready = 1'b1;

      // Reset state
      #2;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_sum", 64'(out_sum_result), 64'd0);
      check("rst_carry", 64'(out_carry), 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk); #1;

      // Int add wrap with carry-out, exact latency
      run_check("int_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 32'h0000_0000, 1'b1, 0);

      // GF add
      run_check("gf_a5", 32'hA5A5_A5A5, 32'h0F0F_0F0F, 2'b01, 32'hAAAA_AAAA, 1'b0, 0);
      run_check("gf_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 32'h0000_0000, 1'b0, 0);
      run_check("mode11", 32'h0000_00FF, 32'h0000_0001, 2'b11,
                SUB_EN ? 32'h0000_0100 : 32'h0000_00FE, 1'b0, 0);

      // Backpressure: hold DONE three cycles while in_valid pulses are offered
      out_ready = 1'b0;
      start_op(32'h1234_5678, 32'h1111_1111, 2'b00);
      wait_done(lat);
      check("bp_lat", 64'(lat), 64'd4);
      held_sum = out_sum_result;
      check("bp_sum", 64'(held_sum), 64'h2345_6789);
      bad = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = i[0] ? 1'b0 : 1'b1;
         in_sum_a = $urandom;
         in_sum_b = $urandom;
         @(posedge clk); #1;
         if (!out_valid || in_ready || out_carry || out_sum_result !== 32'h2345_6789) bad = 1'b1;
      end
      check("bp_stable", 64'(bad), 64'd0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_idle_ready", 64'(in_ready), 64'd1);
      check("bp_idle_vld", 64'(out_valid), 64'd0);

      // Mode 10
`ifdef GF_SEQ_ADDER_SUB_EN
      run_check("sub_7_5", 32'd7, 32'd5, 2'b10, 32'h0000_0002, 1'b1, 0);
      run_check("sub_5_7", 32'd5, 32'd7, 2'b10, 32'hFFFF_FFFE, 1'b0, 0);
`else
      run_check("m10_as_add", 32'd5, 32'd7, 2'b10, 32'h0000_000C, 1'b0, 0);
`endif

      // Reset during RUN discards the op
      start_op(32'hFFFF_FFFF, 32'h0000_0001, 2'b00);
      @(posedge clk); #1;
      @(posedge clk); #1;
      resetn = 1'b0;
      #1;
      check("midrst_sum", 64'(out_sum_result), 64'd0);
      check("midrst_carry", 64'(out_carry), 64'd0);
      check("midrst_vld", 64'(out_valid), 64'd0);
      check("midrst_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      resetn = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (out_valid || !in_ready) bad = 1'b1;
      end
      check("midrst_quiet", 64'(bad), 64'd0);
      run_check("after_rst", 32'd3, 32'd4, 2'b00, 32'h0000_0007, 1'b0, 0);

      // Single-digit instance: one RUN cycle
      v32_in_valid = 1'b1;
      v32_in_sum_a = 32'h8000_0000;
      v32_in_sum_b = 32'h8000_0000;
      v32_in_mode  = 2'b00;
      check("w32_ready", 64'(v32_in_ready), 64'd1);
      @(posedge clk); #1;
      v32_in_valid = 1'b0;
      lat = 0;
      while (!v32_out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("w32_lat", 64'(lat), 64'd1);
      check("w32_sum", 64'(v32_out_sum_result), 64'd0);
      check("w32_carry", 64'(v32_out_carry), 64'd1);
      @(posedge clk); #1;

      // Random ops against the reference model, with random DONE stalls
      for (int n = 0; n < 40; n++) begin
         ra  = $urandom;
         rb  = $urandom;
         rm  = 2'($urandom_range(0, 3));
         exp = model(ra, rb, rm);
         run_check($sformatf("rnd%0d_m%0d", n, rm), ra, rb, rm, exp[31:0], exp[32],
                   int'($urandom_range(0, 2)));
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/gf_seq_adder.md
Name: gf_seq_adder

Overview:
Digit-serial, multi-mode adder for the GF-operations sequential datapath; generalises the fixed ripple-carry adder.
- Processes DIGIT_WIDTH bits per cycle over DATA_WIDTH/DIGIT_WIDTH cycles.
- Supports integer add with carry chained through a register, or carry-less GF(2^m) add (XOR).
- Operands enter and results leave through valid/ready handshakes, so the block plugs between operand staging registers and downstream GF multiply/reduce stages.

Parameters:
DATA_WIDTH, 32, operand and result width in bits
DIGIT_WIDTH, 8, bits processed per cycle; DATA_WIDTH % DIGIT_WIDTH must be 0, otherwise elaboration fails with $error
NUM_DIGITS, DATA_WIDTH/DIGIT_WIDTH, derived localparam; not overridable

Ports:
clk  input  1  clock, rising edge
resetn  input  1  asynchronous active-low reset
in_valid  input  1  operand valid
in_ready  output  1  block can accept operands
in_mode  input  2  00 int add, 01 GF add, 10 int sub (macro only), 11 int add
in_sum_a  input  DATA_WIDTH  operand A
in_sum_b  input  DATA_WIDTH  operand B
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_sum_result  output  DATA_WIDTH  sum / XOR result
out_carry  output  1  integer carry-out; 0 in GF mode

Behaviour:
- Reset:
  - Asynchronous assert forces state IDLE.
  - in_ready=1, out_valid=0, out_sum_result=0, out_carry=0.
  - Operand, carry and digit-counter registers are cleared.
  - Reset mid-RUN or mid-DONE discards the operation; nothing is emitted after release.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid at a rising edge (the accept edge): latch A, B and mode; clear the digit counter; set the carry register (0 for add, 1 for sub); go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle consumes the low digit of A and B.
    - Int: {c, d} = a_d + b_d + carry; carry <= c.
    - GF: d = a_d ^ b_d; carry held 0.
  - d shifts into the result register from the MSB end; A and B shift right by DIGIT_WIDTH.
  - The counter increments; after NUM_DIGITS RUN cycles, go to DONE.
- DONE:
  - out_valid=1; out_sum_result and out_carry hold stable while out_ready=0; in_ready=0.
  - On out_ready, go to IDLE.
- Latency: out_valid rises NUM_DIGITS cycles after the accept edge (N=4 at defaults). Throughput is one operation per NUM_DIGITS+2 cycles minimum.
- in_valid in RUN/DONE is ignored; the upstream source must hold its data until it sees in_ready.
- Mode is sampled only at the accept edge; changes during RUN have no effect.
- Carry chain: digit k's carry-in is digit k-1's carry-out. out_carry is the final digit's carry-out.
- DIGIT_WIDTH==DATA_WIDTH is legal: single RUN cycle.
- Outputs are registered; there are no combinational paths from inputs to out_*. in_ready is decoded from state only.

Optional Feature:
GF_SEQ_ADDER_SUB_EN
- Defined: mode 10 computes A-B as A + ~B + 1.
  - out_carry=1 means no borrow (A>=B unsigned).
- Undefined: in_mode[1] is ignored; 10 behaves as 00 and 11 as 01.
  - No inversion logic is synthesised.

Test Plan:
1. Int add, defaults (32/8): A=0xFFFFFFFF, B=0x00000001, mode 00 -> out_sum_result=0x00000000, out_carry=1, out_valid exactly 4 cycles after accept.
2. GF add: A=0xA5A5A5A5, B=0x0F0F0F0F, mode 01 -> 0xAAAAAAAA, out_carry=0. Repeat with A=B=0xFFFFFFFF -> 0x00000000, carry 0.
3. Backpressure: A=0x12345678, B=0x11111111, mode 00; hold out_ready=0 for 3 cycles in DONE -> result 0x23456789 and carry 0 stable, in_ready=0 throughout; in_valid pulses are ignored; IDLE is entered the cycle after out_ready=1.
4. Subtract, macro defined: 7-5 -> 0x00000002, carry 1; 5-7 -> 0xFFFFFFFE, carry 0. Macro undefined, mode 10 with 5,7 -> 0x0000000C, carry 0.
5. Reset mid-op: accept 0xFFFFFFFF+1, assert resetn=0 after 2 RUN cycles -> outputs zero immediately (asynchronous). After release: in_ready=1, no out_valid; next op 3+4 returns 0x00000007.
6. DIGIT_WIDTH=32: 0x80000000+0x80000000 -> 0x00000000, carry 1, out_valid 1 cycle after accept. DIGIT_WIDTH=5 with DATA_WIDTH=32 -> elaboration error.
